scanout_fetch: RTL and testbench

- Framebuffer scanout prefetcher on the read-only port B of main GPU memory. Each frame it reads a contiguous block of words.
- Fetched words are buffered in a small FIFO and streamed to the display pipeline over a valid/ready interface, with frame-boundary tags.
- Port A stays with the compute core. This block is the sole master of port B: it drives port_b_address and port_b_rd_en, and the integration ties port_b_wr_en to 0.

---
 rtl/scanout_fetch_if.sv | 37 +++
 rtl/scanout_fetch.sv | 144 ++++++++++++++
 tb/tb_scanout_fetch.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scanout_fetch_if.sv
// Bundle between the scanout prefetcher and its two neighbours: memory port B (read side)
// and the display pipeline (valid/ready word stream with frame tags).
interface scanout_fetch_if #(
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned DataWidth = 32
);
  logic [AddrWidth-1:0] mem_address;
  logic                 mem_rd_en;
  logic [DataWidth-1:0] mem_rd_data;
  logic [DataWidth-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_first;
  logic                 out_last;

  modport master (
    output mem_address,
    output mem_rd_en,
    input  mem_rd_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_first,
    output out_last
  );

  modport slave (
    input  mem_address,
    input  mem_rd_en,
    output mem_rd_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_first,
    input  out_last
  );
endinterface

// File: rtl/scanout_fetch.sv
// Framebuffer scanout prefetcher: reads FB_WORDS contiguous words from memory port B per frame
// into a show-ahead FIFO and streams them out with first/last frame tags.
module scanout_fetch #(
  parameter int unsigned CAPACITY_BYTES = 4096,
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned FB_BASE_BYTES  = 0,
  parameter int unsigned FB_WORDS       = 768,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  scanout_fetch_if.master   bus,
  output logic              busy,
  output logic              underrun
);

  localparam int unsigned AW   = $clog2(CAPACITY_BYTES);
  localparam int unsigned DW   = 8 * WORD_BYTES;
  localparam int unsigned CtW  = $clog2(FB_WORDS + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CtW-1:0] FbWords  = CtW'(FB_WORDS);
  localparam logic [CtW-1:0] LastIdx  = CtW'(FB_WORDS - 1);
  localparam logic [AW-1:0]  BaseAddr = AW'(FB_BASE_BYTES);
  localparam logic [AW-1:0]  Step     = AW'(WORD_BYTES);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CtW-1:0]   issued_q, issued_d;
  logic [CtW-1:0]   popped_q, popped_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             rd_pending_q, rd_pending_d;
  logic             fs_q;
  logic [DW-1:0]    fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic rd_en, push, pop, credit, last_beat, out_valid;

  // In-flight reads reserve a slot, so the FIFO can never be overrun by a returning read.
  assign credit = ({1'b0, count_q} + {{CntW{1'b0}}, rd_pending_q}) < (CntW + 1)'(FIFO_DEPTH);

  assign rd_en     = (state_q == StFetch) && (issued_q < FbWords) && credit && !fs_q;
  assign out_valid = (count_q != '0);
  assign push      = rd_pending_q;
  assign pop       = out_valid && bus.out_ready;
  assign last_beat = pop && (popped_q == LastIdx);

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_address = addr_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = fifo_q[rptr_q];
  assign bus.out_first   = out_valid && (popped_q == '0);
  assign bus.out_last    = out_valid && (popped_q == LastIdx);

  assign busy     = (state_q != StIdle);
  assign underrun = busy && bus.out_ready && !out_valid && (popped_q < FbWords);

  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    popped_d     = popped_q;
    addr_d       = addr_q;
    rd_pending_d = rd_en;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;

    if (rd_en) begin
      issued_d = issued_q + CtW'(1);
      addr_d   = addr_q + Step;
    end
    if (pop) begin
      popped_d = popped_q + CtW'(1);
      rptr_d   = rptr_q + PtrW'(1);
    end
    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StIdle:  state_d = StIdle;
      StFetch: if (rd_en && (issued_q == LastIdx)) state_d = StDrain;
      StDrain: if (last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A new frame overrides everything: the read returning now and any read issued now are dropped.
    if (frame_start) begin
      state_d      = StFetch;
      issued_d     = '0;
      popped_d     = '0;
      addr_d       = BaseAddr;
      rd_pending_d = 1'b0;
      wptr_d       = '0;
      rptr_d       = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      issued_q     <= '0;
      popped_q     <= '0;
      addr_q       <= BaseAddr;
      rd_pending_q <= 1'b0;
      fs_q         <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      popped_q     <= popped_d;
      addr_q       <= addr_d;
      rd_pending_q <= rd_pending_d;
      fs_q         <= frame_start;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= bus.mem_rd_data;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (count_q == CntW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_scanout_fetch.sv
// Bench for scanout_fetch: table of frame scenarios plus abort and mid-frame reset sequences,
// with a scoreboard of expected beats built from the bench's own memory image.
module tb_scanout_fetch;
  localparam int unsigned CapBytes  = 4096;
  localparam int unsigned WordBytes = 4;
  localparam int unsigned FbBase    = 64;
  localparam int unsigned FbWords   = 16;
  localparam int unsigned Depth     = 4;
  localparam int unsigned BaseIdx   = FbBase / WordBytes;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_start = 1'b0;
  logic busy, underrun;

  scanout_fetch_if #(.AddrWidth(12), .DataWidth(32)) bus ();

  scanout_fetch #(
    .CAPACITY_BYTES(CapBytes),
    .WORD_BYTES    (WordBytes),
    .FB_BASE_BYTES (FbBase),
    .FB_WORDS      (FbWords),
    .FIFO_DEPTH    (Depth)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .bus        (bus),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  logic [31:0] tbmem [1024];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= tbmem[bus.mem_address[11:2]];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic        first;
    logic        last;
  } beat_t;
  beat_t exp_q[$];

  int cyc = 0;
  int rd_cnt = 0, beats = 0, outstanding = 0, max_out = 0;
  int first_rd_cyc = -1, first_valid_cyc = -1, last_beat_cyc = -100;
  int und_pre = 0, und_post = 0;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      rd_cnt = 0;
      beats = 0;
      outstanding = 0;
    end else begin
      if (cyc == last_beat_cyc + 1) check("busy_fall", 64'(busy), 0);
      if (bus.mem_rd_en) begin
        check("rd_addr", 64'(bus.mem_address), 64'(FbBase + WordBytes * rd_cnt));
        if (rd_cnt == 0) first_rd_cyc = cyc;
        rd_cnt++;
        outstanding++;
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (underrun) begin
        if (first_valid_cyc < 0) und_pre++;
        else und_post++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("beat_pending", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", {bus.out_data, bus.out_first, bus.out_last}, {e.data, e.first, e.last});
          if (e.last) last_beat_cyc = cyc;
        end
        beats++;
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (frame_start) begin
        exp_q.delete();
        for (int i = 0; i < FbWords; i++) begin
          e.data  = tbmem[BaseIdx + i];
          e.first = (i == 0);
          e.last  = (i == FbWords - 1);
          exp_q.push_back(e);
        end
        rd_cnt = 0;
        beats = 0;
        outstanding = 0;
        max_out = 0;
        first_rd_cyc = -1;
        first_valid_cyc = -1;
        und_pre = 0;
        und_post = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int mode;       // 0 ready high, 1 ready low for 'stall' cycles, 2 random ready
    int stall;
    int exp_reads;  // reads issued by the end of the stall
    int exp_und_pre;
  } vec_t;

  task automatic set_ready(input vec_t v, input int k);
    if (v.mode == 0) bus.out_ready = 1'b1;
    else if (v.mode == 1) bus.out_ready = (k >= v.stall);
    else bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(output bit done);
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      tick();
      if (!busy) done = 1;
    end
  endtask

  task automatic run_frame(input vec_t v);
    bit done;
    frame_start = 1'b1;
    set_ready(v, 0);
    tick();
    frame_start = 1'b0;
    done = 0;
    for (int k = 1; k < 400 && !done; k++) begin
      if (v.mode == 1 && k == v.stall) begin
        check("stall_reads", 64'(rd_cnt), 64'(v.exp_reads));
        check("stall_rd_en", 64'(bus.mem_rd_en), 0);
      end
      set_ready(v, k);
      tick();
      if (!busy) done = 1;
    end
    check("frame_done", 64'(done), 1);
    tick();
    tick();
    check("beats", 64'(beats), 64'(FbWords));
    check("reads", 64'(rd_cnt), 64'(FbWords));
    check("sb_empty", 64'(exp_q.size()), 0);
    check("max_outstanding_ok", 64'(max_out <= Depth), 1);
    if (v.mode == 0) begin
      check("latency", 64'(first_valid_cyc - first_rd_cyc), 2);
      check("no_bubbles", 64'(last_beat_cyc - first_valid_cyc), 64'(FbWords - 1));
      check("underrun_pre", 64'(und_pre), 64'(v.exp_und_pre));
      check("underrun_post", 64'(und_post), 0);
    end
  endtask

  task automatic check_idle(input string p);
    check({p, "_rd_en"}, 64'(bus.mem_rd_en), 0);
    check({p, "_addr"}, 64'(bus.mem_address), 64'(FbBase));
    check({p, "_valid"}, 64'(bus.out_valid), 0);
    check({p, "_first"}, 64'(bus.out_first), 0);
    check({p, "_last"}, 64'(bus.out_last), 0);
    check({p, "_busy"}, 64'(busy), 0);
    check({p, "_underrun"}, 64'(underrun), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    bit   found;
    bit   done;
    int   cnt;
    vecs[0] = '{mode: 0, stall: 0,  exp_reads: 0, exp_und_pre: 3};
    vecs[1] = '{mode: 1, stall: 20, exp_reads: 4, exp_und_pre: 0};
    vecs[2] = '{mode: 2, stall: 0,  exp_reads: 0, exp_und_pre: 0};
    vecs[3] = '{mode: 2, stall: 0,  exp_reads: 0, exp_und_pre: 0};
    vecs[4] = '{mode: 2, stall: 0,  exp_reads: 0, exp_und_pre: 0};

    for (int i = 0; i < 1024; i++) tbmem[i] = 32'hDEAD_0000 + i;
    for (int i = 0; i < FbWords; i++) tbmem[BaseIdx + i] = 32'hA000_0000 + i;

    bus.out_ready = 1'b0;
    repeat (2) tick();
    check_idle("reset");
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Abort while beat 7 is at the head; words 8..15 of the old frame must never appear.
    bus.out_ready = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (beats == 7 && bus.out_valid) found = 1;
      else tick();
    end
    check("abort_reach", 64'(found), 1);
    tbmem[BaseIdx] = 32'h1234_5678;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_idle(done);
    check("abort_done", 64'(done), 1);
    tick();
    tick();
    check("abort_beats", 64'(beats), 64'(FbWords));
    check("abort_sb_empty", 64'(exp_q.size()), 0);

    // Reset for one cycle after the 5th read of a frame.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (rd_cnt >= 5) found = 1;
      else tick();
    end
    check("reset_reach", 64'(found), 1);
    reset_n = 1'b0;
    #1;
    check_idle("midreset");
    tick();
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.out_valid || bus.mem_rd_en || busy) cnt++;
    end
    check("post_reset_quiet", 64'(cnt), 0);

    run_frame(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
